// File: rtl/ibex_bloom_ctrl_if.sv
// Request/result bundle between the ID/EX pipeline and the Bloom-filter sequencer.
//
// Handshake rules:
//   request: an op is accepted on a rising clock edge when req_i & ready_o & !kill_i;
//            op_i/operand_a_i/operand_b_i are sampled on that edge only.
//   result : result_o is meaningful while valid_o is high and stays stable until the
//            result is consumed; valid_o & ack_i on a clock edge consumes it, and
//            kill_i while valid_o is high drops it.
// state_dbg mirrors the sequencer FSM state for checkers and debug.
interface ibex_bloom_ctrl_if;
    logic        req_i;
    logic [1:0]  op_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        kill_i;
    logic        ack_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic        busy_o;
    logic [1:0]  state_dbg;

    modport master (
        output req_i, op_i, operand_a_i, operand_b_i, kill_i, ack_i,
        input  ready_o, valid_o, result_o, busy_o, state_dbg
    );

    modport slave (
        input  req_i, op_i, operand_a_i, operand_b_i, kill_i, ack_i,
        output ready_o, valid_o, result_o, busy_o, state_dbg
    );
endinterface

// File: rtl/ibex_bloom_ctrl.sv
// Multi-cycle sequencer for the EX-stage Bloom-filter unit. Owns the filter bit
// array, walks NumHashes double-hash probes for INSERT/CHECK, clears the array one
// 32-bit word per cycle for CLEAR, and returns a 32-bit result under valid/ack.
// Optional feature macro: IBEX_BLOOM_STATS_EN adds a saturating counter of INSERTs
// that found a new key; COUNT returns it (32'h0 when the macro is undefined).
module ibex_bloom_ctrl #(
    parameter int unsigned NumBits   = 256,
    parameter int unsigned NumHashes = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ibex_bloom_ctrl_if.slave  bus
);

    localparam int unsigned L        = $clog2(NumBits);
    localparam int unsigned NumWords = NumBits / 32;
    localparam int unsigned WW       = (NumWords > 1) ? $clog2(NumWords) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HASH  = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_INSERT = 2'd0,
        OP_CHECK  = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_COUNT  = 2'd3
    } op_e;

    state_e             state_q, state_d;
    op_e                op_q;
    logic [L-1:0]       idx_q;
    logic [L-1:0]       stride_q;
    logic [3:0]         probe_q;
    logic [WW-1:0]      clr_q;
    logic               hit_q;
    logic [31:0]        result_q;
    logic [NumBits-1:0] bits_q;

    logic               accept;
    logic               probe_bit;
    logic               hit_next;
    logic               last_probe;
    logic               clr_last;
    logic               set_bit;
    logic               load_result;
    logic [31:0]        result_d;
    logic [31:0]        count_val;
    logic               insert_new_done;

    // Only the low L bits of each operand address the array.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{bus.operand_a_i[31:L], bus.operand_b_i[31:L]};

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the per-cycle control strobes for the datapath.
    always_comb begin
        state_d         = state_q;
        accept          = 1'b0;
        set_bit         = 1'b0;
        load_result     = 1'b0;
        result_d        = result_q;
        insert_new_done = 1'b0;
        probe_bit       = bits_q[idx_q];
        hit_next        = hit_q & probe_bit;
        last_probe      = (probe_q == 4'(NumHashes - 1));
        clr_last        = (clr_q == WW'(NumWords - 1));
        unique case (state_q)
            IDLE: begin
                // kill_i in the same cycle as req_i suppresses the accept.
                if (bus.req_i && !bus.kill_i) begin
                    accept = 1'b1;
                    unique case (op_e'(bus.op_i))
                        OP_INSERT, OP_CHECK: state_d = HASH;
                        OP_CLEAR:            state_d = CLEAR;
                        OP_COUNT: begin
                            state_d     = DONE;
                            load_result = 1'b1;
                            result_d    = count_val;
                        end
                    endcase
                end
            end
            HASH: begin
                if (bus.kill_i) begin
                    state_d = IDLE;
                end else begin
                    set_bit = (op_q == OP_INSERT);
                    if (last_probe || ((op_q == OP_CHECK) && !probe_bit)) begin
                        state_d         = DONE;
                        load_result     = 1'b1;
                        result_d        = {31'd0, hit_next};
                        insert_new_done = (op_q == OP_INSERT) && !hit_next;
                    end
                end
            end
            CLEAR: begin
                // A flush never interrupts a clear: the array must end up empty.
                if (clr_last) begin
                    state_d     = DONE;
                    load_result = 1'b1;
                    result_d    = 32'd0;
                end
            end
            DONE: begin
                if (bus.kill_i || bus.ack_i) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Datapath: operand latch, probe walk, bit array updates and result register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bits_q   <= '0;
            op_q     <= OP_INSERT;
            idx_q    <= '0;
            stride_q <= '0;
            probe_q  <= '0;
            clr_q    <= '0;
            hit_q    <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q     <= op_e'(bus.op_i);
                idx_q    <= bus.operand_a_i[L-1:0];
                stride_q <= bus.operand_b_i[L-1:0];
                probe_q  <= '0;
                clr_q    <= '0;
                hit_q    <= 1'b1;
            end
            if ((state_q == HASH) && !bus.kill_i) begin
                hit_q   <= hit_next;
                idx_q   <= idx_q + stride_q;
                probe_q <= probe_q + 4'd1;
            end
            if (set_bit) begin
                bits_q[idx_q] <= 1'b1;
            end
            if (state_q == CLEAR) begin
                bits_q[{clr_q, 5'd0} +: 32] <= 32'd0;
                clr_q                       <= clr_q + 1'b1;
            end
            if (load_result) begin
                result_q <= result_d;
            end
        end
    end

`ifdef IBEX_BLOOM_STATS_EN
    logic [31:0] stats_q;

    // Saturating count of INSERTs that added a new key; a finished CLEAR empties it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stats_q <= '0;
        end else if ((state_q == CLEAR) && clr_last) begin
            stats_q <= '0;
        end else if (insert_new_done && (stats_q != 32'hFFFF_FFFF)) begin
            stats_q <= stats_q + 32'd1;
        end
    end

    assign count_val = stats_q;
`else
    logic unused_insert_new_done;
    assign unused_insert_new_done = insert_new_done;
    assign count_val              = 32'd0;
`endif

    assign bus.ready_o   = (state_q == IDLE);
    assign bus.valid_o   = (state_q == DONE);
    assign bus.busy_o    = (state_q != IDLE);
    assign bus.result_o  = result_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_ibex_bloom_ctrl.sv
// Bench for ibex_bloom_ctrl: an op-level Bloom-filter model (bit array, stats
// counter, latency arithmetic) predicts result and cycle timing for every op; a
// per-cycle compare process checks the handshake outputs against it.
module tb_ibex_bloom_ctrl;

    localparam int NB = 256;
    localparam int K  = 3;

    localparam logic [1:0] OP_INS = 2'd0;
    localparam logic [1:0] OP_CHK = 2'd1;
    localparam logic [1:0] OP_CLR = 2'd2;
    localparam logic [1:0] OP_CNT = 2'd3;

    logic clk;
    logic rst;

    ibex_bloom_ctrl_if bus ();

    ibex_bloom_ctrl #(.NumBits(NB), .NumHashes(K)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model state ----------------
    logic [NB-1:0] m_bits;
    logic [31:0]   m_count;

    // expected per-cycle outputs
    logic        chk_en;
    logic        exp_ready;
    logic        exp_busy;
    logic        exp_valid;
    logic [31:0] exp_result;

    int vectors;
    int miscompares;

    logic [31:0] exp_q[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready_o", {31'd0, bus.ready_o}, {31'd0, exp_ready});
            check("busy_o",  {31'd0, bus.busy_o},  {31'd0, exp_busy});
            check("valid_o", {31'd0, bus.valid_o}, {31'd0, exp_valid});
            if (exp_valid) begin
                check("result_o", bus.result_o, exp_result);
            end
        end
    end

    // ---------------- behavioural model ----------------
    // Predicts result, cycle of valid_o (lat, counted from the accept cycle) and
    // whether a kill pulse in cycle kill_at aborts the op; updates the model array.
    task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int kill_at, output int lat, output logic [31:0] res,
                            output bit killed);
        logic [31:0] pos;
        int          idx;
        bit          hit;
        killed = 1'b0;
        res    = 32'd0;
        lat    = 1;
        case (op)
            OP_INS: begin
                lat    = K + 1;
                killed = (kill_at >= 1) && (kill_at <= K);
                hit    = 1'b1;
                for (int p = 0; p < K; p++) begin
                    if (killed && (p >= kill_at - 1)) break;
                    pos = a + b * p;
                    idx = int'(pos % NB);
                    hit = hit & m_bits[idx];
                    m_bits[idx] = 1'b1;
                end
                res = {31'd0, hit};
                if (!killed && !hit && (m_count != 32'hFFFF_FFFF)) m_count = m_count + 1;
            end
            OP_CHK: begin
                lat = K + 1;
                res = 32'd1;
                for (int p = 0; p < K; p++) begin
                    pos = a + b * p;
                    idx = int'(pos % NB);
                    if (!m_bits[idx]) begin
                        res = 32'd0;
                        lat = p + 2;
                        break;
                    end
                end
                killed = (kill_at >= 1) && (kill_at < lat);
            end
            OP_CLR: begin
                lat     = NB / 32 + 1;
                m_bits  = '0;
                m_count = 32'd0;
                res     = 32'd0;
            end
            default: begin
                lat = 1;
`ifdef IBEX_BLOOM_STATS_EN
                res = m_count;
`else
                res = 32'd0;
`endif
            end
        endcase
    endtask

    task automatic set_idle();
        exp_ready = 1'b1;
        exp_busy  = 1'b0;
        exp_valid = 1'b0;
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1 with the DUT idle. kill_at pulses kill_i in that cycle
    // after accept (0 = never); ack_wait extra DONE cycles pass before the ack
    // (or the kill when kill_done is set). got returns result_o seen in DONE.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int kill_at, input int ack_wait, input bit kill_done,
                          output logic [31:0] got);
        int          lat;
        logic [31:0] res;
        bit          killed;
        model_op(op, a, b, kill_at, lat, res, killed);
        got = 32'hDEAD_BEEF;
        bus.req_i       = 1'b1;
        bus.op_i        = op;
        bus.operand_a_i = a;
        bus.operand_b_i = b;
        @(posedge clk); #1;
        bus.req_i       = 1'b0;
        bus.op_i        = 2'($urandom_range(0, 3));
        bus.operand_a_i = $urandom;
        bus.operand_b_i = $urandom;
        if (lat > 1) begin
            exp_ready = 1'b0;
            exp_busy  = 1'b1;
            exp_valid = 1'b0;
        end
        for (int c = 1; c < lat; c++) begin
            if (c == kill_at) bus.kill_i = 1'b1;
            @(posedge clk); #1;
            bus.kill_i = 1'b0;
            if (killed && (c == kill_at)) begin
                set_idle();
                return;
            end
        end
        exp_ready  = 1'b0;
        exp_busy   = 1'b1;
        exp_valid  = 1'b1;
        exp_result = res;
        exp_q.push_back(res);
        for (int w = 0; w <= ack_wait; w++) begin
            if (w == ack_wait) begin
                if (kill_done) bus.kill_i = 1'b1;
                else           bus.ack_i  = 1'b1;
            end
            @(negedge clk);
            if (w == 0) got = bus.result_o;
            @(posedge clk); #1;
        end
        bus.ack_i  = 1'b0;
        bus.kill_i = 1'b0;
        void'(exp_q.pop_front());
        set_idle();
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] got;
    logic [31:0] a_pool[8];
    logic [31:0] b_pool[8];
    int          r;
    logic [1:0]  rop;

    initial begin
        bus.req_i       = 1'b0;
        bus.op_i        = 2'd0;
        bus.operand_a_i = 32'd0;
        bus.operand_b_i = 32'd0;
        bus.kill_i      = 1'b0;
        bus.ack_i       = 1'b0;
        chk_en          = 1'b0;
        vectors         = 0;
        miscompares     = 0;
        m_bits          = '0;
        m_count         = 32'd0;
        exp_result      = 32'd0;
        set_idle();

        // reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_result", bus.result_o, 32'd0);
        @(posedge clk); #1;

        // empty filter: CHECK misses on the first probe (valid 2 cycles after accept)
        run_op(OP_CHK, 32'h10, 32'h21, 0, 0, 1'b0, got);
        check("check_empty", got, 32'd0);
        // new key, then duplicate, then CHECK hits
        run_op(OP_INS, 32'h10, 32'h21, 0, 0, 1'b0, got);
        check("insert_new", got, 32'd0);
        check("bits_10_31_52", {29'd0, m_bits[8'h10], m_bits[8'h31], m_bits[8'h52]}, 32'd7);
        run_op(OP_INS, 32'h10, 32'h21, 0, 0, 1'b0, got);
        check("insert_dup", got, 32'd1);
        run_op(OP_CHK, 32'h10, 32'h21, 0, 1, 1'b0, got);
        check("check_hit", got, 32'd1);
        // wrap-around probes F0,10,30; CHECK 10,30,50 misses on the third probe
        run_op(OP_INS, 32'hF0, 32'h20, 0, 0, 1'b0, got);
        check("insert_wrap", got, 32'd0);
        run_op(OP_CHK, 32'h10, 32'h20, 0, 0, 1'b0, got);
        check("check_third_miss", got, 32'd0);
        // stride 0 probes one bit three times; 0x30 was set by the wrap insert
        run_op(OP_CHK, 32'h130, 32'h0, 0, 0, 1'b0, got);
        check("check_stride0", got, 32'd1);
        // result held while ack_i stays low for 5 cycles
        run_op(OP_CHK, 32'hF0, 32'h20, 0, 5, 1'b0, got);
        check("check_ack_hold", got, 32'd1);
        // CLEAR with a kill pulse mid-way still completes
        run_op(OP_CLR, 32'h0, 32'h0, 4, 0, 1'b0, got);
        check("clear_result", got, 32'd0);
        run_op(OP_CHK, 32'h10, 32'h21, 0, 0, 1'b0, got);
        check("check_after_clear", got, 32'd0);
        // kill on the 2nd HASH cycle of an INSERT: first probe bit survives
        run_op(OP_INS, 32'h40, 32'h11, 2, 0, 1'b0, got);
        run_op(OP_CHK, 32'h40, 32'h0, 0, 0, 1'b0, got);
        check("killed_insert_first_bit", got, 32'd1);
        run_op(OP_CLR, 32'h0, 32'h0, 0, 0, 1'b0, got);
        // kill while DONE drops the result
        run_op(OP_INS, 32'h77, 32'h05, 0, 1, 1'b1, got);
        check("insert_kill_done", got, 32'd0);
        // req_i together with kill_i in IDLE: no accept
        bus.req_i  = 1'b1;
        bus.op_i   = OP_CHK;
        bus.kill_i = 1'b1;
        @(posedge clk); #1;
        bus.req_i  = 1'b0;
        bus.kill_i = 1'b0;
        @(posedge clk); #1;
        // reset during HASH returns to IDLE and empties the array
        bus.req_i       = 1'b1;
        bus.op_i        = OP_INS;
        bus.operand_a_i = 32'h20;
        bus.operand_b_i = 32'h01;
        @(posedge clk); #1;
        bus.req_i = 1'b0;
        exp_ready = 1'b0;
        exp_busy  = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        m_bits  = '0;
        m_count = 32'd0;
        set_idle();
        @(negedge clk);
        check("rst_mid_result", bus.result_o, 32'd0);
        @(posedge clk); #1;
        run_op(OP_CHK, 32'h77, 32'h05, 0, 0, 1'b0, got);
        check("check_after_rst", got, 32'd0);
        // two new keys and one duplicate, then COUNT
        run_op(OP_INS, 32'h01, 32'h03, 0, 0, 1'b0, got);
        run_op(OP_INS, 32'h02, 32'h03, 0, 0, 1'b0, got);
        run_op(OP_INS, 32'h01, 32'h03, 0, 0, 1'b0, got);
        check("insert_dup2", got, 32'd1);
        run_op(OP_CNT, 32'h0, 32'h0, 0, 0, 1'b0, got);
`ifdef IBEX_BLOOM_STATS_EN
        check("count", got, 32'd2);
`else
        check("count", got, 32'd0);
`endif

        // randomized ops over a small key pool so hits and duplicates occur
        for (int i = 0; i < 8; i++) begin
            a_pool[i] = $urandom;
            b_pool[i] = $urandom;
        end
        b_pool[0] = 32'd0;
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      rop = OP_INS;
            else if (r < 85) rop = OP_CHK;
            else if (r < 93) rop = OP_CLR;
            else             rop = OP_CNT;
            run_op(rop, a_pool[$urandom_range(0, 7)], b_pool[$urandom_range(0, 7)],
                   (rop == OP_CLR) ? $urandom_range(0, 8) : 0,
                   $urandom_range(0, 3), ($urandom_range(0, 9) == 0), got);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ibex_bloom_ctrl.md
Name: ibex_bloom_ctrl

Overview:
- Multi-cycle sequencer for the EX-stage custom Bloom-filter unit; owns the filter bit array.
- Decoded INSERT/CHECK/CLEAR/COUNT ops enter through a request/ready handshake; the block walks K double-hash probes (or clears the array word by word), then presents a 32-bit result under a valid/ack handshake.
- Sits beside the ALU and mult/div in the EX block; its valid feeds EX valid when a custom op is selected.

Parameters:
- NumBits, 256, filter size in bits; power of two, 32..4096.
- NumHashes, 3, probes per INSERT/CHECK; 1..8.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous reset, active-high.
- req_i  input  1  op request from ID/EX; accepted when req_i & ready_o.
- op_i  input  2  00 INSERT, 01 CHECK, 10 CLEAR, 11 COUNT; sampled on accept.
- operand_a_i  input  32  key hash seed (rs1); sampled on accept.
- operand_b_i  input  32  probe stride (rs2); sampled on accept.
- kill_i  input  1  pipeline flush; aborts the in-flight op (see Behaviour).
- ack_i  input  1  ID ready to take the result (multdiv_ready_id-style).
- ready_o  output  1  high only in IDLE.
- valid_o  output  1  result valid; high in DONE.
- result_o  output  32  op result; held stable while valid_o is high.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - State -> IDLE; bit array all 0; probe counter, clear counter and result register 0.
  - Outputs: ready_o=1, valid_o=0, busy_o=0, result_o=0.
- State IDLE:
  - On accept, latch idx = operand_a_i[L-1:0] (L = log2 NumBits) and stride = operand_b_i[L-1:0].
  - Probe counter j = 0; `hit` flag = 1.
  - Next state: INSERT/CHECK -> HASH, CLEAR -> CLEAR, COUNT -> DONE.
- State HASH, one probe per cycle:
  - Read bit[idx]; hit &= bit[idx].
  - INSERT also sets bit[idx] at that clock edge.
  - idx <= (idx + stride) mod NumBits, i.e. L-bit wrap-around with the carry discarded. A stride of 0 probes the same bit K times; this is legal.
  - INSERT: exactly NumHashes cycles, then DONE.
  - CHECK: DONE after NumHashes cycles, or the cycle after the first probe that reads 0 (early exit).
- Latency:
  - INSERT: accept + K + 1 cycles to valid_o.
  - CHECK: same as INSERT when all probed bits are set; fewer on a miss.
- State CLEAR:
  - Zero one 32-bit word per cycle, word index 0..NumBits/32-1, then DONE.
  - Takes NumBits/32 cycles.
- Results:
  - INSERT: 32'h1 if every probed bit was already set (key already present), else 0.
  - CHECK: 32'h1 if all probes hit, else 0.
  - CLEAR: 0.
  - COUNT: see Optional Feature.
- State DONE:
  - valid_o=1; leave to IDLE when ack_i=1.
  - valid_o and ack_i in the same cycle completes the op; the next request can be accepted the following cycle.
  - No new request is accepted while in DONE.
- kill_i:
  - In HASH: -> IDLE next cycle, no valid_o. Bits already set by a partial INSERT remain set; this is acceptable for a Bloom filter.
  - In DONE: -> IDLE, result dropped.
  - In CLEAR: ignored; the clear always completes.
  - In IDLE: no effect. req_i and kill_i in the same IDLE cycle: kill wins, no accept.
- result_o, once written on the transition into DONE, holds its value until the next accept.

Optional Feature:
- Macro: IBEX_BLOOM_STATS_EN.
- Defined:
  - Adds a 32-bit saturating insert counter, incremented on each completed INSERT that returns 0.
  - Counter clears on reset and on a completed CLEAR.
  - COUNT returns the counter value.
- Not defined:
  - No counter flops.
  - COUNT returns 32'h0.
  - COUNT still takes one cycle to DONE.

Test Plan:
- Reset, then CHECK a=0x10 b=0x21 -> result 0; valid_o 2 cycles after accept (early exit on the first probe).
- INSERT a=0x10 b=0x21 (K=3, NumBits=256) -> bits 0x10, 0x31, 0x52 set; result 0 at accept+4. Repeat the same INSERT -> result 1. CHECK same key -> result 1 at accept+4.
- INSERT a=0xF0 b=0x20 -> probes 0xF0, 0x10 (wrap), 0x30; CHECK a=0x10 b=0x20 -> probes 0x10, 0x30, 0x50 -> result 0 at the 3rd probe (0x50 unset).
- CLEAR after inserts -> busy_o for 8 cycles, then valid_o; any prior CHECK -> 0. A kill_i raised mid-CLEAR still completes the clear.
- kill_i on the 2nd HASH cycle of an INSERT -> no valid_o, ready_o next cycle, the first probe bit remains set. Hold ack_i=0 for 5 cycles -> valid_o and result_o stable throughout. rst_i during HASH -> IDLE and array cleared.
- IBEX_BLOOM_STATS_EN defined: 2 new-key INSERTs + 1 duplicate, then COUNT -> 32'h2; without the macro COUNT -> 32'h0.
